// File: rtl/boot_image_loader.sv
// Program-load-and-run sequencer: packs an image byte stream into memory words, arms the
// to-host mailbox, releases the selected cores and polls the mailbox until clear or timeout.
module boot_image_loader #(
    parameter int unsigned         ADDR_W      = 64,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         NUM_CORES   = 1,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0]   TOHOST_ADDR = ADDR_W'(64'h0008_C120),
    parameter logic [31:0]         SENTINEL    = 32'hDEADBEEF,
    parameter int unsigned         POLL_CYC    = 64,
    parameter int unsigned         TIMEOUT_CYC = 2500
) (
    input  logic                   clk_main_a0,
    input  logic                   rst_main_n,
    input  logic                   start,
    input  logic [NUM_CORES-1:0]   core_mask,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    output logic                   byte_ready,
    output logic                   mem_wr_req,
    output logic [ADDR_W-1:0]      mem_wr_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    output logic [DATA_W/8-1:0]    mem_wr_strb,
    input  logic                   mem_wr_ack,
    output logic                   mem_rd_req,
    output logic [ADDR_W-1:0]      mem_rd_addr,
    input  logic                   mem_rd_valid,
    input  logic [31:0]            mem_rd_data,
    output logic [NUM_CORES-1:0]   core_rst_n,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timed_out,
    output logic [31:0]            bytes_loaded
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LaneW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StWrWord, StArm, StRelease, StWait, StRead, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_CORES-1:0]  mask_q, mask_d;
    logic [NUM_CORES-1:0]  core_rst_q, core_rst_d;
    logic [DATA_W-1:0]     word_q, word_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic [LaneW-1:0]      lane_q, lane_d;
    logic                  last_q, last_d;
    logic [ADDR_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic [31:0]           bytes_q, bytes_d;
    logic [31:0]           tmo_q, tmo_d;
    logic [31:0]           poll_q, poll_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  tout_q, tout_d;
    logic                  start_ok;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        core_rst_d  = core_rst_q;
        word_d      = word_q;
        strb_d      = strb_q;
        lane_d      = lane_q;
        last_d      = last_q;
        wr_cnt_d    = wr_cnt_q;
        bytes_d     = bytes_q;
        tmo_d       = tmo_q;
        poll_d      = poll_q;
        done_d      = done_q;
        pass_d      = pass_q;
        tout_d      = tout_q;
        start_ok    = 1'b0;
        byte_ready  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        mem_wr_strb = '0;
        mem_rd_req  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    start_ok   = 1'b1;
                    mask_d     = core_mask;
                    core_rst_d = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    tout_d     = 1'b0;
                    bytes_d    = '0;
                    lane_d     = '0;
                    word_d     = '0;
                    strb_d     = '0;
                    last_d     = 1'b0;
                    wr_cnt_d   = '0;
                    state_d    = StLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    word_d[8*lane_q +: 8] = byte_data;
                    strb_d[lane_q]        = 1'b1;
                    if (bytes_q != '1) bytes_d = bytes_q + 32'd1;
                    if (byte_last || lane_q == LaneW'(NB - 1)) begin
                        last_d  = byte_last;
                        state_d = StWrWord;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            StWrWord: begin
                mem_wr_req  = 1'b1;
                mem_wr_addr = BASE_ADDR + wr_cnt_q * ADDR_W'(NB);
                mem_wr_data = word_q;
                mem_wr_strb = strb_q;
                if (mem_wr_ack) begin
                    lane_d   = '0;
                    word_d   = '0;
                    strb_d   = '0;
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = last_q ? StArm : StLoad;
                end
            end
            StArm: begin
                mem_wr_req  = 1'b1;
                mem_wr_addr = TOHOST_ADDR;
                mem_wr_data = DATA_W'(SENTINEL);
                mem_wr_strb = NB'(4'hF);
                if (mem_wr_ack) state_d = StRelease;
            end
            StRelease: begin
                core_rst_d = mask_q;
                tmo_d      = '0;
                poll_d     = '0;
                state_d    = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 32'd1;
                if (tmo_q >= TIMEOUT_CYC - 1) begin
                    tout_d  = 1'b1;
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (poll_q >= POLL_CYC - 1) begin
                    poll_d  = '0;
                    state_d = StRead;
                end else begin
                    poll_d = poll_q + 32'd1;
                end
            end
            StRead: begin
                // Timeout keeps counting but is only acted on once the response is in.
                mem_rd_req = 1'b1;
                tmo_d      = tmo_q + 32'd1;
                if (mem_rd_valid) begin
                    if (mem_rd_data == 32'd0) begin
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (tmo_q >= TIMEOUT_CYC - 1) begin
                        tout_d  = 1'b1;
                        pass_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            core_rst_q <= '0;
            word_q     <= '0;
            strb_q     <= '0;
            lane_q     <= '0;
            last_q     <= 1'b0;
            wr_cnt_q   <= '0;
            bytes_q    <= '0;
            tmo_q      <= '0;
            poll_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            core_rst_q <= core_rst_d;
            word_q     <= word_d;
            strb_q     <= strb_d;
            lane_q     <= lane_d;
            last_q     <= last_d;
            wr_cnt_q   <= wr_cnt_d;
            bytes_q    <= bytes_d;
            tmo_q      <= tmo_d;
            poll_q     <= poll_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tout_q     <= tout_d;
        end
    end

    // A fresh start pulls every core back into reset in the same cycle it is seen.
    assign core_rst_n   = start_ok ? '0 : core_rst_q;
    assign mem_rd_addr  = TOHOST_ADDR;
    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = done_q;
    assign pass         = pass_q;
    assign timed_out    = tout_q;
    assign bytes_loaded = bytes_q;

endmodule

// File: doc/boot_image_loader.md
Name: boot_image_loader

Overview:
- Hardware sequencer for the program-load-and-run flow on the custom-logic shell.
- Accepts a byte stream of a program image (hex-file contents forwarded by the host/DMA shim) and packs it into DATA_W-bit words written to DDR/BRAM through a simple write port.
- Then arms the to-host mailbox with a sentinel, releases reset on the selected cores, polls the mailbox with a timeout and reports pass/fail.
- Successor to the per-byte, single-core load flow: parametrised in word width, core count, mailbox address and timeout, with byte-strobe flushing and periodic polling.

Parameters:
- ADDR_W, 64, memory address width
- DATA_W, 32, memory write word width; multiple of 8, range 8..512
- NUM_CORES, 1, number of core reset outputs
- BASE_ADDR, 64'h0, address of image byte 0
- TOHOST_ADDR, 64'h0008_C120, mailbox address
- SENTINEL, 32'hDEADBEEF, value armed into mailbox before release
- POLL_CYC, 64, cycles between mailbox reads
- TIMEOUT_CYC, 2500, cycles after release before fail is declared

Ports:
- clk_main_a0  in  1  sole clock
- rst_main_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a load; ignored while busy
- core_mask  in  NUM_CORES  cores to release; sampled on start
- byte_valid  in  1  image byte valid
- byte_data  in  8  image byte
- byte_last  in  1  marks final image byte; qualified by byte_valid
- byte_ready  out  1  loader accepts byte
- mem_wr_req  out  1  write request
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- mem_wr_strb  out  DATA_W/8  byte enables
- mem_wr_ack  in  1  write accepted
- mem_rd_req  out  1  mailbox read request
- mem_rd_addr  out  ADDR_W  always TOHOST_ADDR
- mem_rd_valid  in  1  read data valid
- mem_rd_data  in  32  read data
- core_rst_n  out  NUM_CORES  per-core reset; active low
- busy  out  1  high from start until done
- done  out  1  sticky completion; cleared by next start
- pass  out  1  valid when done=1
- timed_out  out  1  valid when done=1
- bytes_loaded  out  32  count of accepted image bytes

Behaviour:
- Reset: all outputs 0, including core_rst_n (all cores held) and bytes_loaded; state IDLE. Reset mid-operation aborts the transfer at once, drops req outputs, re-asserts all core resets and discards partial words.
- States: IDLE -> LOAD -> (WR_WORD <-> LOAD) -> ARM -> RELEASE -> WAIT -> READ -> WAIT/DONE. DONE returns to IDLE in one cycle; done, pass and timed_out stay sticky.
- IDLE, start=1:
  - latch core_mask;
  - clear done, pass, timed_out, bytes_loaded and the byte lane index;
  - hold all core_rst_n=0.
- LOAD:
  - byte_ready=1; a byte is accepted when byte_valid&&byte_ready.
  - Byte k of a word goes to bits [8k+7:8k] (little-endian); bytes_loaded increments by 1 per accepted byte.
  - The word is issued (-> WR_WORD) when the lane reaches DATA_W/8-1 or byte_last is accepted. A partial final word carries strobe bits only for filled lanes.
- WR_WORD:
  - byte_ready=0; mem_wr_req=1 with address, data and strobe stable until mem_wr_ack is sampled high.
  - Write n goes to address BASE_ADDR + n*(DATA_W/8).
  - On ack: lane reset, word buffer cleared; go to ARM if the word held byte_last, else return to LOAD.
  - Ack in the same cycle req first rises is legal (1-cycle write).
- ARM: write SENTINEL zero-extended to DATA_W at TOHOST_ADDR, full low 4 strobes, same handshake.
- RELEASE: one cycle; core_rst_n[i]=1 for each i with mask[i]=1. Clear the timeout counter and the poll counter.
- WAIT:
  - timeout counter increments every cycle; poll counter counts to POLL_CYC-1, then go to READ.
  - When the timeout counter reaches TIMEOUT_CYC-1: timed_out=1, pass=0, -> DONE.
- READ:
  - mem_rd_req held until mem_rd_valid. The timeout counter keeps running and is checked only after the response.
  - rd_data==0 -> pass=1, DONE. Otherwise return to WAIT.
  - If the timeout is reached during READ, that response is still checked first.
- DONE: done=1, busy=0; core_rst_n left as released. A new start re-asserts all core resets on the same cycle.
- Other rules:
  - start while busy has no effect.
  - byte_valid outside LOAD is not accepted.
  - Zero-length images are not supported; byte_last is required.
  - bytes_loaded saturates at 32'hFFFF_FFFF.
  - Writes never overlap reads; only one outstanding request at a time.

Test Plan:
- DATA_W=32, bytes 00..07 with last on 07, ack immediate -> writes 0x03020100@0x0 and 0x07060504@0x4, strb 4'hF both; bytes_loaded=8.
- DATA_W=32, 5 bytes AA..EE -> second write data 0x000000EE, strb 4'h1, addr 0x4; then sentinel write 0xDEADBEEF@0x8C120.
- Ack delayed 7 cycles per write -> req, addr and data stable for all 7 cycles; byte_ready=0 throughout; no byte is lost under continuous byte_valid.
- Model clears the mailbox 300 cycles after release, core_mask=2'b10 with NUM_CORES=2 -> core_rst_n=2'b10; after the next poll, done=1, pass=1, timed_out=0.
- Mailbox never cleared, TIMEOUT_CYC=2500 -> done at cycle 2500 after release with pass=0 and timed_out=1; about 39 reads issued at POLL_CYC=64.
- rst_main_n low for 1 cycle mid-WR_WORD -> mem_wr_req=0, core_rst_n=0, bytes_loaded=0 next cycle; a fresh start then loads correctly from BASE_ADDR.
